// File: rtl/mrx_tag_sync_capture_pkg.sv
// Shared definitions for the anchor-side tag sync framer: state encodings, GPIO bit map
// and sync-pulse timing defaults common with the tag-side controller.
package mrx_tag_sync_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_LOW = 2'b01,
        ST_MEAS     = 2'b10,
        ST_CAPTURE  = 2'b11
    } cap_state_t;

    // Tag drives LOC_SYNCH/HOP_TX on its 0x001/0x010 mask; they land on anchor mask 0x022.
    localparam int              GPIO_SYNC_BIT  = 1;
    localparam int              GPIO_TX_BIT    = 5;
    localparam logic [11:0]     GPIO_IN_MASK   = 12'h022;

    localparam int              NSIG_DEFAULT     = 16384;
    localparam int              SYNC_TOL_DEFAULT = 64;

    localparam int              TX_WINDOW = 16;
    localparam int              TX_TMR_W  = $clog2(TX_WINDOW);

endpackage

// File: rtl/mrx_tag_sync_capture_gpio_sync_edge.sv
// Two-flop synchronizer for one asynchronous GPIO line, plus rise/fall detect on the
// synchronized copy. No reset, so the synchronized level is already valid when reset lifts.
module mrx_tag_sync_capture_gpio_sync_edge
    import mrx_tag_sync_capture_pkg::*;
(
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sr;

    always_ff @(posedge clk) begin
        sr <= {sr[1:0], din};
    end

    assign level = sr[1];
    assign rise  = sr[1] & ~sr[2];
    assign fall  = ~sr[1] & sr[2];

endmodule

// File: rtl/mrx_tag_sync_capture.sv
// Receive framer: validates the tag's LOC_SYNCH pulse length, then gates one hop of RX IQ
// samples onto the output stream with hop index and tlast.
module mrx_tag_sync_capture
    import mrx_tag_sync_capture_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int PHASE_WIDTH    = 24,
    parameter int NHOP_WIDTH     = 8,
    parameter int GPIO_REG_WIDTH = 12,
    parameter int SYNC_IN_BIT    = GPIO_SYNC_BIT,
    parameter int TX_IN_BIT      = GPIO_TX_BIT,
    parameter int NSIG           = NSIG_DEFAULT,
    parameter int SYNC_TOL       = SYNC_TOL_DEFAULT,
    parameter int NSYMB_PER_HOP  = 8,
    parameter int NUM_HOPS       = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [GPIO_REG_WIDTH-1:0] fp_gpio_in,
    input  logic [DATA_WIDTH-1:0]     in_idata,
    input  logic [DATA_WIDTH-1:0]     in_qdata,
    input  logic                      in_tvalid,
    output logic [DATA_WIDTH-1:0]     out_idata,
    output logic [DATA_WIDTH-1:0]     out_qdata,
    output logic                      out_tvalid,
    output logic                      out_tlast,
    input  logic                      out_tready,
    output logic [NHOP_WIDTH-1:0]     hop_idx,
    output logic [PHASE_WIDTH-1:0]    samp_idx,
    output logic [1:0]                state,
    output logic [PHASE_WIDTH-1:0]    sync_len,
    output logic                      sync_err,
    output logic [15:0]               drop_cnt
);

    localparam int                       CAP_LEN  = NSIG * NSYMB_PER_HOP;
    localparam logic [PHASE_WIDTH-1:0]   LAST_IDX = PHASE_WIDTH'(CAP_LEN - 1);
    localparam logic [NHOP_WIDTH-1:0]    LAST_HOP = NHOP_WIDTH'(NUM_HOPS - 1);
    localparam logic signed [PHASE_WIDTH:0] NSIG_S = (PHASE_WIDTH + 1)'(NSIG);
    localparam logic signed [PHASE_WIDTH:0] TOL_S  = (PHASE_WIDTH + 1)'(SYNC_TOL);

    logic sync_lvl, sync_rise, sync_fall;
    logic tx_lvl, tx_rise_unused, tx_fall_unused;
    logic unused_gpio;

    mrx_tag_sync_capture_gpio_sync_edge u_sync_edge (
        .clk   (clk),
        .din   (fp_gpio_in[SYNC_IN_BIT]),
        .level (sync_lvl),
        .rise  (sync_rise),
        .fall  (sync_fall)
    );

    mrx_tag_sync_capture_gpio_sync_edge u_tx_edge (
        .clk   (clk),
        .din   (fp_gpio_in[TX_IN_BIT]),
        .level (tx_lvl),
        .rise  (tx_rise_unused),
        .fall  (tx_fall_unused)
    );

    assign unused_gpio = ^{fp_gpio_in, tx_rise_unused, tx_fall_unused};

    cap_state_t              state_q, state_d;
    logic                    armed_q, armed_d;
    logic [PHASE_WIDTH-1:0]  len_q, len_d;
    logic [TX_TMR_W-1:0]     tx_tmr_q, tx_tmr_d;
    logic                    tx_ok_q, tx_ok_d;
    logic [DATA_WIDTH-1:0]   idata_d, qdata_d;
    logic                    tvalid_d, tlast_d, err_d;
    logic [NHOP_WIDTH-1:0]   hop_d;
    logic [PHASE_WIDTH-1:0]  samp_d, slen_d;
    logic [15:0]             drop_d;
    logic signed [PHASE_WIDTH:0] len_diff;
    logic                    len_ok, at_last, tx_timeout;

    // Signed, one bit wider than the counter, so a saturated length cannot wrap into range.
    assign len_diff   = $signed({1'b0, len_q}) - NSIG_S;
    assign len_ok     = (len_diff <= TOL_S) && (len_diff >= -TOL_S);
    assign at_last    = (samp_idx == LAST_IDX);
    assign tx_timeout = !(tx_ok_q | tx_lvl) && (tx_tmr_q == '0);

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q;
        len_d    = len_q;
        tx_tmr_d = tx_tmr_q;
        tx_ok_d  = tx_ok_q;
        idata_d  = out_idata;
        qdata_d  = out_qdata;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        err_d    = 1'b0;
        hop_d    = hop_idx;
        samp_d   = samp_idx;
        slen_d   = sync_len;
        drop_d   = drop_cnt;
        case (state_q)
            ST_IDLE: begin
                armed_d = 1'b0;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (armed_q && sync_rise) begin
                    state_d = ST_MEAS;
                    len_d   = PHASE_WIDTH'(1);
                    armed_d = 1'b0;
                end else if (!sync_lvl) begin
                    armed_d = 1'b1;
                end
            end
            ST_MEAS: begin
                if (sync_fall) begin
                    slen_d = len_q;
                    if (len_ok) begin
                        state_d  = ST_CAPTURE;
                        samp_d   = '0;
                        tx_tmr_d = TX_TMR_W'(TX_WINDOW - 1);
                        tx_ok_d  = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_LOW;
                    end
                end else if (len_q != '1) begin
                    len_d = len_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                tx_ok_d = tx_ok_q | tx_lvl;
                if (tx_tmr_q != '0)
                    tx_tmr_d = tx_tmr_q - 1'b1;
                if (in_tvalid) begin
                    if (out_tready) begin
                        tvalid_d = 1'b1;
                        idata_d  = in_idata;
                        qdata_d  = in_qdata;
                    end else if (drop_cnt != 16'hFFFF) begin
                        drop_d = drop_cnt + 1'b1;
                    end
                    // Any sample that ends the hop, normally or by abort, closes the stream.
                    tlast_d = at_last | sync_rise | tx_timeout;
                    if (!at_last)
                        samp_d = samp_idx + 1'b1;
                end
                if (sync_rise) begin
                    err_d   = 1'b1;
                    state_d = ST_MEAS;
                    len_d   = PHASE_WIDTH'(1);
                end else if (tx_timeout) begin
                    err_d   = 1'b1;
                    state_d = ST_WAIT_LOW;
                    armed_d = 1'b0;
                end else if (in_tvalid && at_last) begin
                    hop_d   = (hop_idx == LAST_HOP) ? '0 : hop_idx + 1'b1;
                    state_d = ST_WAIT_LOW;
                    armed_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            len_q      <= '0;
            tx_tmr_q   <= '0;
            tx_ok_q    <= 1'b0;
            out_idata  <= '0;
            out_qdata  <= '0;
            out_tvalid <= 1'b0;
            out_tlast  <= 1'b0;
            sync_err   <= 1'b0;
            hop_idx    <= '0;
            samp_idx   <= '0;
            sync_len   <= '0;
            drop_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            len_q      <= len_d;
            tx_tmr_q   <= tx_tmr_d;
            tx_ok_q    <= tx_ok_d;
            out_idata  <= idata_d;
            out_qdata  <= qdata_d;
            out_tvalid <= tvalid_d;
            out_tlast  <= tlast_d;
            sync_err   <= err_d;
            hop_idx    <= hop_d;
            samp_idx   <= samp_d;
            sync_len   <= slen_d;
            drop_cnt   <= drop_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mrx_tag_sync_capture.sv
// Bench for mrx_tag_sync_capture: table of sync pulses plus random sample streams checked
// against a queue-based model of which inputs belong to each captured hop.
module tb_mrx_tag_sync_capture;
    import mrx_tag_sync_capture_pkg::*;

    localparam int NSIG_T = 64;
    localparam int TOL_T  = 4;
    localparam int CAP_T  = 128;
    localparam int HOPS_T = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] fp_gpio_in = '0;
    logic [15:0] in_idata = '0, in_qdata = '0;
    logic        in_tvalid = 1'b0;
    logic [15:0] out_idata, out_qdata;
    logic        out_tvalid, out_tlast;
    logic        out_tready = 1'b1;
    logic [7:0]  hop_idx;
    logic [23:0] samp_idx;
    logic [1:0]  state;
    logic [23:0] sync_len;
    logic        sync_err;
    logic [15:0] drop_cnt;

    mrx_tag_sync_capture #(
        .NSIG(NSIG_T), .SYNC_TOL(TOL_T), .NSYMB_PER_HOP(2), .NUM_HOPS(HOPS_T)
    ) dut (
        .clk(clk), .reset(reset), .fp_gpio_in(fp_gpio_in),
        .in_idata(in_idata), .in_qdata(in_qdata), .in_tvalid(in_tvalid),
        .out_idata(out_idata), .out_qdata(out_qdata), .out_tvalid(out_tvalid),
        .out_tlast(out_tlast), .out_tready(out_tready), .hop_idx(hop_idx),
        .samp_idx(samp_idx), .state(state), .sync_len(sync_len),
        .sync_err(sync_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct { logic [15:0] i; logic [15:0] q; logic last; } samp_t;
    typedef struct { int len; bit tx; bit accept; } vec_t;

    samp_t exp_q[$];
    int    checks = 0, failures = 0;
    int    err_cnt = 0, hop_exp = 0, drop_exp = 0;
    bit    sync_v = 1'b0, tx_v = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sync_err) err_cnt++;
        if (out_tvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out actual=i%h q%h last%0d required=none",
                         out_idata, out_qdata, out_tlast);
            end else begin
                samp_t e;
                e = exp_q.pop_front();
                if ({out_idata, out_qdata, out_tlast} !== {e.i, e.q, e.last}) begin
                    failures++;
                    $display("FAIL sample actual=i%h q%h last%0d required=i%h q%h last%0d",
                             out_idata, out_qdata, out_tlast, e.i, e.q, e.last);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [15:0] i, input logic [15:0] q, input bit rdy);
        in_tvalid  = v;
        in_idata   = i;
        in_qdata   = q;
        out_tready = rdy;
        fp_gpio_in = (12'($urandom) & 12'hFDD) | (12'(sync_v) << 1) | (12'(tx_v) << 5);
    endtask

    task automatic idle(input int n);
        repeat (n) begin tick(); drive(1'b0, '0, '0, 1'b1); end
    endtask

    task automatic send_pulse(input int len, input bit tx_after);
        sync_v = 1'b1;
        tx_v   = 1'b0;
        idle(len);
        tick();
        sync_v = 1'b0;
        tx_v   = tx_after;
        drive(1'b0, '0, '0, 1'b1);
        idle(6);
    endtask

    // Drives random-valid samples until one hop's worth has been offered; valid cycles with
    // index in [20, 20+n_drop) see tready low and are dropped.
    task automatic capture_full(input int n_drop);
        int k = 0;
        logic [15:0] di, dq;
        bit v, rdy;
        while (k < CAP_T) begin
            tick();
            v   = ($urandom_range(0, 3) != 0);
            rdy = !(v && k >= 20 && k < 20 + n_drop);
            di  = 16'($urandom);
            dq  = 16'($urandom);
            drive(v, di, dq, rdy);
            if (v) begin
                if (rdy) exp_q.push_back('{di, dq, (k == CAP_T - 1)});
                else drop_exp++;
                k++;
            end
        end
        repeat (10) begin tick(); drive(1'b1, 16'($urandom), 16'($urandom), 1'b1); end
        idle(5);
        hop_exp = (hop_exp + 1) % HOPS_T;
    endtask

    task automatic run_vec(input string tag, input int len, input bit tx, input bit accept);
        int e0 = err_cnt;
        send_pulse(len, tx);
        if (accept && tx) begin
            capture_full(0);
            chk({tag, "_err"}, err_cnt - e0, 0);
        end else begin
            idle(30);
            repeat (60) begin tick(); drive(1'b1, 16'($urandom), 16'($urandom), 1'b1); end
            idle(5);
            chk({tag, "_err"}, err_cnt - e0, 1);
        end
        chk({tag, "_sync_len"}, sync_len, len);
        chk({tag, "_hop"}, hop_idx, hop_exp);
        chk({tag, "_state"}, state, ST_WAIT_LOW);
        chk({tag, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[8];
        int   e0;
        logic [15:0] di, dq;

        vecs = '{'{64, 1'b1, 1'b1}, '{59, 1'b1, 1'b0}, '{69, 1'b1, 1'b0}, '{60, 1'b1, 1'b1},
                 '{68, 1'b1, 1'b1}, '{64, 1'b0, 1'b0}, '{66, 1'b1, 1'b1}, '{62, 1'b1, 1'b1}};

        // Reset state
        idle(5);
        @(negedge clk);
        chk("rst_state", state, ST_IDLE);
        chk("rst_out", {out_tvalid, out_tlast, sync_err, out_idata, out_qdata}, 0);
        chk("rst_regs", {hop_idx, samp_idx, sync_len, drop_cnt}, 0);
        tick(); reset = 1'b0; drive(1'b0, '0, '0, 1'b1);
        idle(5);
        chk("post_rst_state", state, ST_WAIT_LOW);

        // Pulse-length window, missing tx, hop index wrap 0,1,2,3,0,1
        foreach (vecs[n])
            run_vec($sformatf("vec%0d_len%0d", n, vecs[n].len), vecs[n].len, vecs[n].tx, vecs[n].accept);

        // Randomized pulse lengths around nominal
        for (int r = 0; r < 4; r++) begin
            int len = $urandom_range(NSIG_T - 8, NSIG_T + 8);
            int d   = (len > NSIG_T) ? len - NSIG_T : NSIG_T - len;
            run_vec($sformatf("rnd%0d_len%0d", r, len), len, 1'b1, d <= TOL_T);
        end

        // New sync rise mid-capture: abort at sample 50, that pulse starts the next hop
        e0 = err_cnt;
        send_pulse(64, 1'b1);
        for (int j = 0; j <= 50; j++) begin
            tick();
            if (j == 48) sync_v = 1'b1;
            di = 16'($urandom);
            dq = 16'($urandom);
            drive(1'b1, di, dq, 1'b1);
            exp_q.push_back('{di, dq, (j == 50)});
        end
        idle(2);
        chk("abort_err", err_cnt - e0, 1);
        chk("abort_hop", hop_idx, hop_exp);
        chk("abort_state", state, ST_MEAS);
        chk("abort_pending", exp_q.size(), 0);
        send_pulse(59, 1'b1);
        capture_full(0);
        chk("abort_next_len", sync_len, 64);
        chk("abort_next_hop", hop_idx, hop_exp);
        chk("abort_next_err", err_cnt - e0, 1);

        // Backpressure drops
        send_pulse(64, 1'b1);
        capture_full(10);
        chk("drop_cnt", drop_cnt, drop_exp);
        chk("drop_hop", hop_idx, hop_exp);
        chk("drop_pending", exp_q.size(), 0);

        // Reset mid-capture with sync high across release
        send_pulse(64, 1'b1);
        for (int j = 0; j < 30; j++) begin
            tick();
            di = 16'($urandom);
            dq = 16'($urandom);
            drive(1'b1, di, dq, 1'b1);
            exp_q.push_back('{di, dq, 1'b0});
        end
        tick(); reset = 1'b1; sync_v = 1'b1; drive(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        tick(); drive(1'b0, '0, '0, 1'b1);
        @(negedge clk);
        chk("mid_rst_state", state, ST_IDLE);
        chk("mid_rst_out", {out_tvalid, out_tlast, sync_err, out_idata, out_qdata}, 0);
        chk("mid_rst_regs", {hop_idx, samp_idx, sync_len, drop_cnt}, 0);
        chk("mid_rst_pending", exp_q.size(), 0);
        hop_exp  = 0;
        drop_exp = 0;
        idle(2);
        e0 = err_cnt;
        tick(); reset = 1'b0; drive(1'b0, '0, '0, 1'b1);
        repeat (20) begin tick(); drive(1'b1, 16'($urandom), 16'($urandom), 1'b1); end
        sync_v = 1'b0;
        idle(10);
        chk("rel_err", err_cnt - e0, 0);
        chk("rel_state", state, ST_WAIT_LOW);
        chk("rel_sync_len", sync_len, 0);
        run_vec("after_rst", 64, 1'b1, 1'b1);
        chk("final_drop", drop_cnt, drop_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
